body_regfile: RTL and testbench
===============================

BODY_REGFILE -- requirements
Module: body_regfile

Interface
REQ-001 SHALL have port: CLK  input  1  system clock, all logic on rising edge.
REQ-002 SHALL have port: RESET  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: AVL_CS / AVL_READ / AVL_WRITE  input  1 each  host select, read strobe, write strobe.
REQ-004 SHALL have port: AVL_ADDR  input  7  host word address, 0..112.
REQ-005 SHALL have ports: AVL_WRITEDATA  input  32  host write data; AVL_READDATA  output  32  host read data.
REQ-006 SHALL have ports: FSM_we  input  1  physics-engine write enable; ADDR1/ADDR2/ADDR3  input  32 each  engine word addresses; data1/data2/data3  input  32 each  engine write data.
REQ-007 SHALL have ports: FSM_START  output  1  step request to engine; FSM_DONE  input  1  engine step complete.
REQ-008 SHALL have port: datafile  output  113 x 32  live register contents to engine.

Function
REQ-009 SHALL hold 113 x 32-bit words; word 0 NUM (body count, host R/W), word 1 CTRL/STATUS, word 2 STEP_COUNT (read-only), words 3..112 body data (host R/W).
REQ-010 CTRL write: bit0 GO (write-1 starts step, self-clearing); bit2 write-1 clears DONE. Read: bit1 BUSY, bit2 DONE (sticky), others 0.
REQ-011 SHALL implement controller states IDLE, RUN, DRAIN.
REQ-012 IDLE: FSM_START=0, BUSY=0; host write to word 1 with bit0=1 -> RUN next cycle.
REQ-013 RUN: FSM_START=1, BUSY=1; on FSM_DONE=1 -> DRAIN.
REQ-014 DRAIN: FSM_START=0, BUSY=1; on FSM_DONE=0 -> IDLE, set DONE, increment STEP_COUNT (wraps 0xFFFFFFFF->0).
REQ-015 GO while BUSY=1 SHALL be ignored; clearing DONE and setting GO in one write: DONE cleared, step starts.
REQ-016 Engine writes SHALL be accepted only in RUN or DRAIN with FSM_we=1; each of ADDR1..3 written independently, same edge.
REQ-017 Engine addresses outside 3..112 SHALL be dropped per port; other ports unaffected.
REQ-018 Multiple engine ports on same address: ADDR3 beats ADDR2 beats ADDR1.
REQ-019 Host writes to words 0 and 3..112 SHALL be dropped while BUSY=1; writes to word 2 always dropped.
REQ-020 Host reads: AVL_READDATA valid 1 cycle after AVL_CS&AVL_READ, holds until next read; addresses >112 return 0.
REQ-021 Host read of a word written the same cycle SHALL return pre-write value.
REQ-022 datafile SHALL reflect every accepted write one cycle after the write edge.

Reset
REQ-023 RESET SHALL clear all 113 words, AVL_READDATA, DONE, FSM_START to 0 and force IDLE on the next edge.
REQ-024 RESET mid-RUN/DRAIN SHALL abort step: FSM_START 0 after that edge, STEP_COUNT and DONE remain 0, pending engine writes dropped.
REQ-025 RESET SHALL take priority over all host and engine writes in the same cycle.

Configuration
REQ-026 Macro STEP_COUNT_EN: when defined, word 2 counts completed steps per REQ-014; when undefined, counter absent, word 2 reads 0, all else identical.

Verification
REQ-027 Reset, host write word 5=0x3F800000, read word 5 -> READDATA=0x3F800000 one cycle after read; datafile[5]=0x3F800000.
REQ-028 Write CTRL=0x1 -> FSM_START=1 next cycle, CTRL read=0x2; FSM_DONE=1 -> FSM_START=0; FSM_DONE=0 -> CTRL read=0x4, STEP_COUNT=1 (STEP_COUNT_EN defined).
REQ-029 In RUN, FSM_we=1, ADDR1=53, ADDR2=63, ADDR3=73, data=0x40000000/0x40400000/0x40800000 -> all three words updated; host write 0x1 to word 53 same step dropped.
REQ-030 In RUN, ADDR1=ADDR2=ADDR3=22 with data 1/2/3 -> word 22=3; ADDR1=200 -> dropped, ADDR2/3 still written.
REQ-031 RESET asserted in RUN -> FSM_START=0 next cycle, all words 0; engine writes in IDLE (FSM_we=1) -> no change.
REQ-032 STEP_COUNT_EN undefined: complete one step -> word 2 reads 0, DONE=1.

Source files
------------

// File: rtl/body_regfile.sv
`default_nettype none
// ============================================================================
// Module   : body_regfile
// Purpose  : 113 x 32-bit body/control register file shared between a host
//            (Avalon-style port) and a physics engine, with a GO/DONE step
//            controller. Optional macro STEP_COUNT_EN enables the STEP_COUNT
//            counter in word 2 (reads 0 when undefined).
// Revision : 1.0  initial release
// ============================================================================
module body_regfile (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        AVL_CS,
    input  logic        AVL_READ,
    input  logic        AVL_WRITE,
    input  logic [6:0]  AVL_ADDR,
    input  logic [31:0] AVL_WRITEDATA,
    output logic [31:0] AVL_READDATA,
    input  logic        FSM_we,
    input  logic [31:0] ADDR1,
    input  logic [31:0] ADDR2,
    input  logic [31:0] ADDR3,
    input  logic [31:0] data1,
    input  logic [31:0] data2,
    input  logic [31:0] data3,
    output logic        FSM_START,
    input  logic        FSM_DONE,
    output logic [31:0] datafile [0:112]
);

    localparam int        WORDS      = 113;
    localparam logic [6:0] ADDR_NUM  = 7'd0;
    localparam logic [6:0] ADDR_CTRL = 7'd1;
    localparam logic [6:0] ADDR_LAST = 7'd112;
    localparam logic [6:0] ADDR_BODY = 7'd3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]  state;
    logic [1:0]  state_next;
    logic        busy;
    logic        done;
    logic [31:0] mem [0:WORDS-1];
    logic [31:0] step_word;

    logic        host_wr;
    logic        host_ctrl_wr;
    logic        host_data_addr;
    logic        go_req;
    logic        step_done;
    logic        eng_wr;
    logic        eng_ok1;
    logic        eng_ok2;
    logic        eng_ok3;

    assign host_wr        = AVL_CS && AVL_WRITE;
    assign host_ctrl_wr   = host_wr && (AVL_ADDR == ADDR_CTRL);
    assign host_data_addr = (AVL_ADDR == ADDR_NUM) ||
                            ((AVL_ADDR >= ADDR_BODY) && (AVL_ADDR <= ADDR_LAST));
    assign go_req         = host_ctrl_wr && AVL_WRITEDATA[0];
    assign step_done      = (state == ST_DRAIN) && !FSM_DONE;

    // Engine ports only reach the body area; control/status words are never engine-writable.
    assign eng_wr  = FSM_we && busy;
    assign eng_ok1 = (ADDR1 >= 32'd3) && (ADDR1 <= 32'd112);
    assign eng_ok2 = (ADDR2 >= 32'd3) && (ADDR2 <= 32'd112);
    assign eng_ok3 = (ADDR3 >= 32'd3) && (ADDR3 <= 32'd112);

    // ------------------------------------------------------------------
    // Step controller
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (go_req)    state_next = ST_RUN;
            ST_RUN:   if (FSM_DONE)  state_next = ST_DRAIN;
            ST_DRAIN: if (!FSM_DONE) state_next = ST_IDLE;
            default:                 state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        FSM_START = 1'b0;
        busy      = 1'b0;
        case (state)
            ST_RUN: begin
                FSM_START = 1'b1;
                busy      = 1'b1;
            end
            ST_DRAIN: begin
                busy      = 1'b1;
            end
            default: begin
                FSM_START = 1'b0;
                busy      = 1'b0;
            end
        endcase
    end

    // A completing step outranks a simultaneous host clear so no completion is lost.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            done <= 1'b0;
        end else if (step_done) begin
            done <= 1'b1;
        end else if (host_ctrl_wr && AVL_WRITEDATA[2]) begin
            done <= 1'b0;
        end
    end

`ifdef STEP_COUNT_EN
    logic [31:0] step_count;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            step_count <= '0;
        end else if (step_done) begin
            step_count <= step_count + 32'd1;
        end
    end

    assign step_word = step_count;
`else
    assign step_word = '0;
`endif

    // ------------------------------------------------------------------
    // Storage: later assignments win, giving ADDR3 > ADDR2 > ADDR1.
    // Host and engine never collide since host data writes need !busy.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < WORDS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (host_wr && host_data_addr && !busy) begin
                mem[AVL_ADDR] <= AVL_WRITEDATA;
            end
            if (eng_wr) begin
                if (eng_ok1) mem[ADDR1[6:0]] <= data1;
                if (eng_ok2) mem[ADDR2[6:0]] <= data2;
                if (eng_ok3) mem[ADDR3[6:0]] <= data3;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < WORDS; i++) begin
            datafile[i] = mem[i];
        end
        datafile[1] = {29'd0, done, busy, 1'b0};
        datafile[2] = step_word;
    end

    // ------------------------------------------------------------------
    // Host read port: registered, holds between reads, pre-write value.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            AVL_READDATA <= '0;
        end else if (AVL_CS && AVL_READ) begin
            if (AVL_ADDR <= ADDR_LAST) begin
                AVL_READDATA <= datafile[AVL_ADDR];
            end else begin
                AVL_READDATA <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_body_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_body_regfile
// Purpose  : Scoreboard bench for body_regfile: directed scenarios followed by
//            randomized host/engine traffic against a behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_body_regfile;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        AVL_CS, AVL_READ, AVL_WRITE;
    logic [6:0]  AVL_ADDR;
    logic [31:0] AVL_WRITEDATA;
    logic [31:0] AVL_READDATA;
    logic        FSM_we;
    logic [31:0] ADDR1, ADDR2, ADDR3;
    logic [31:0] data1, data2, data3;
    logic        FSM_START;
    logic        FSM_DONE;
    logic [31:0] datafile [0:112];

    body_regfile dut (
        .CLK(CLK), .RESET(RESET),
        .AVL_CS(AVL_CS), .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE),
        .AVL_ADDR(AVL_ADDR), .AVL_WRITEDATA(AVL_WRITEDATA), .AVL_READDATA(AVL_READDATA),
        .FSM_we(FSM_we), .ADDR1(ADDR1), .ADDR2(ADDR2), .ADDR3(ADDR3),
        .data1(data1), .data2(data2), .data3(data3),
        .FSM_START(FSM_START), .FSM_DONE(FSM_DONE), .datafile(datafile)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: words, controller phase (0 idle, 1 running, 2 draining)
    logic [31:0] m [0:112];
    int          phase;
    bit          mdone;
    logic [31:0] mcnt;
    logic [31:0] exp_q [$];

    function automatic logic [31:0] view(int i);
        if (i == 1) return {29'd0, mdone, (phase != 0), 1'b0};
`ifdef STEP_COUNT_EN
        if (i == 2) return mcnt;
`else
        if (i == 2) return 32'd0;
`endif
        return m[i];
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    task automatic check_all();
        int bad;
        check("fsm_start", {31'd0, FSM_START}, {31'd0, phase == 1});
        bad = -1;
        for (int i = 0; i < 113; i++) if (bad < 0 && datafile[i] !== view(i)) bad = i;
        n_checks++;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL datafile[%0d]: got 0x%08h expected 0x%08h", bad, datafile[bad], view(bad));
        end
    endtask

    task automatic eng_write(logic [31:0] a, logic [31:0] d);
        if (a >= 3 && a <= 112) m[a] = d;
    endtask

    // Apply the currently driven inputs to the model, then advance one clock.
    task automatic step();
        int  nphase;
        bit  busy;
        if (RESET) begin
            for (int i = 0; i < 113; i++) m[i] = '0;
            phase = 0; mdone = 0; mcnt = '0;
        end else begin
            if (AVL_CS && AVL_READ) exp_q.push_back(AVL_ADDR <= 112 ? view(int'(AVL_ADDR)) : 32'd0);
            busy   = (phase != 0);
            nphase = phase;
            if (AVL_CS && AVL_WRITE) begin
                if (AVL_ADDR == 1) begin
                    if (AVL_WRITEDATA[2]) mdone = 0;
                    if (AVL_WRITEDATA[0] && !busy) nphase = 1;
                end else if ((AVL_ADDR == 0 || (AVL_ADDR >= 3 && AVL_ADDR <= 112)) && !busy) begin
                    m[AVL_ADDR] = AVL_WRITEDATA;
                end
            end
            if (busy && FSM_we) begin
                eng_write(ADDR1, data1);
                eng_write(ADDR2, data2);
                eng_write(ADDR3, data3);
            end
            if (phase == 1 && FSM_DONE) nphase = 2;
            if (phase == 2 && !FSM_DONE) begin
                nphase = 0;
                mdone  = 1;
                mcnt   = mcnt + 32'd1;
            end
            phase = nphase;
        end
        @(posedge CLK);
        #1;
        check_all();
    endtask

    task automatic quiet();
        RESET = 0; AVL_CS = 0; AVL_READ = 0; AVL_WRITE = 0; AVL_ADDR = '0; AVL_WRITEDATA = '0;
        FSM_we = 0; ADDR1 = '0; ADDR2 = '0; ADDR3 = '0; data1 = '0; data2 = '0; data3 = '0;
    endtask

    task automatic host_wr(logic [6:0] a, logic [31:0] d);
        AVL_CS = 1; AVL_WRITE = 1; AVL_ADDR = a; AVL_WRITEDATA = d;
        step();
        AVL_CS = 0; AVL_WRITE = 0;
    endtask

    task automatic host_rd(logic [6:0] a);
        AVL_CS = 1; AVL_READ = 1; AVL_ADDR = a;
        step();
        AVL_CS = 0; AVL_READ = 0;
    endtask

    task automatic eng(logic [31:0] a1, logic [31:0] a2, logic [31:0] a3,
                       logic [31:0] d1, logic [31:0] d2, logic [31:0] d3);
        FSM_we = 1; ADDR1 = a1; ADDR2 = a2; ADDR3 = a3; data1 = d1; data2 = d2; data3 = d3;
        step();
        FSM_we = 0;
    endtask

    // Monitor: read data appears the cycle after a read and holds otherwise.
    logic [31:0] last_rd = '0;
    initial begin
        bit seen_rd, seen_rst;
        forever begin
            @(posedge CLK);
            seen_rd  = AVL_CS && AVL_READ;
            seen_rst = RESET;
            #1;
            if (seen_rst) begin
                last_rd = '0;
            end else if (seen_rd) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL readdata: got 0x%08h expected nothing queued", AVL_READDATA);
                end else begin
                    last_rd = exp_q.pop_front();
                end
            end
            check("readdata", AVL_READDATA, last_rd);
        end
    end

    initial begin
        quiet();
        FSM_DONE = 0;
        RESET = 1;
        for (int i = 0; i < 113; i++) m[i] = 32'hDEAD_BEEF;
        step(); step();
        RESET = 0;
        check("reset_readdata", AVL_READDATA, 32'd0);

        // Basic host write/read
        host_wr(7'd5, 32'h3F80_0000);
        check("word5_datafile", datafile[5], 32'h3F80_0000);
        host_rd(7'd5);
        host_wr(7'd0, 32'd7);
        host_rd(7'd0);
        host_rd(7'd120);

        // One complete step
        host_wr(7'd1, 32'h1);
        check("start_after_go", {31'd0, FSM_START}, 32'd1);
        host_rd(7'd1);
        FSM_DONE = 1; step();
        check("start_in_drain", {31'd0, FSM_START}, 32'd0);
        FSM_DONE = 0; step();
        host_rd(7'd1);
        host_rd(7'd2);
        check("ctrl_done", datafile[1], 32'h4);

        // Clear DONE and GO in one write; engine writes during RUN
        host_wr(7'd1, 32'h5);
        check("ctrl_busy_cleared", datafile[1], 32'h2);
        AVL_CS = 1; AVL_WRITE = 1; AVL_ADDR = 7'd53; AVL_WRITEDATA = 32'h1;
        eng(32'd53, 32'd63, 32'd73, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000);
        AVL_CS = 0; AVL_WRITE = 0;
        check("word53", datafile[53], 32'h4000_0000);
        host_wr(7'd1, 32'h1);                 // GO while busy ignored
        eng(32'd22, 32'd22, 32'd22, 32'd1, 32'd2, 32'd3);
        check("word22", datafile[22], 32'd3);
        eng(32'd200, 32'd30, 32'd31, 32'h11, 32'h22, 32'h33);
        eng(32'd1, 32'd2, 32'd112, 32'h44, 32'h55, 32'h66);
        host_wr(7'd2, 32'h99);
        host_rd(7'd31);

        // Reset mid-RUN with engine writes in the same cycle
        RESET = 1;
        eng(32'd40, 32'd41, 32'd42, 32'h7, 32'h8, 32'h9);
        RESET = 0;
        check("reset_word22", datafile[22], 32'd0);
        eng(32'd10, 32'd11, 32'd12, 32'h1, 32'h2, 32'h3);   // idle: ignored
        host_rd(7'd2);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            RESET     = ($urandom_range(0, 299) == 0);
            AVL_CS    = ($urandom_range(0, 3) != 0);
            AVL_READ  = $urandom_range(0, 1) == 1;
            AVL_WRITE = ($urandom_range(0, 2) == 0);
            AVL_ADDR  = ($urandom_range(0, 3) == 0) ? 7'd1 : 7'($urandom_range(0, 127));
            AVL_WRITEDATA = (AVL_ADDR == 7'd1) ? ($urandom & 32'h7) : $urandom;
            FSM_we    = $urandom_range(0, 1) == 1;
            ADDR1     = $urandom_range(0, 130);
            ADDR2     = ($urandom_range(0, 9) == 0) ? $urandom : $urandom_range(0, 115);
            ADDR3     = $urandom_range(0, 120);
            data1 = $urandom; data2 = $urandom; data3 = $urandom;
            FSM_DONE  = ($urandom_range(0, 2) == 0);
            step();
        end

        quiet();
        FSM_DONE = 0;
        step(); step(); step();
        check("queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
